l2_line_responder: RTL and testbench

// - Responder (memory-side) end of the arbiter -> L2 request interface. Accepts one

---
 rtl/l2_line_responder.sv | 114 +++++++++++
 tb/tb_l2_line_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_line_responder.sv
// l2_line_responder: memory-side end of the arbiter -> L2 request path.
// Accepts one line read/write at a time, runs it as a BEATS-beat burst on
// the memory port, then pulses resp for one cycle.
//
// Handshake: a command (mem_read) or write beat (mem_write + mem_wdata) is
// transferred on a rising edge where it is asserted and mem_ready=1; it stays
// asserted and stable until then. Read beats transfer on any edge with
// mem_rvalid=1 while in RD_DATA and are never back-pressured.
module l2_line_responder #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [LINE_BITS-1:0] req_wdata,
  output logic                 resp,
  output logic [LINE_BITS-1:0] resp_rdata,
  output logic [31:0]          mem_addr,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [BEAT_BITS-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [BEAT_BITS-1:0] mem_rdata,
  input  logic                 mem_rvalid,
  output logic [2:0]           dbg_state
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_CMD   = 3'd1;
  localparam logic [2:0] RD_DATA  = 3'd2;
  localparam logic [2:0] WR_BURST = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [31:0]          addr_q;
  logic [LINE_BITS-1:0] wdata_q;

  // Request capture, burst sequencing and beat counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_read || req_write) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= '0;
            // Write has priority when both request lines are high.
            state   <= req_write ? WR_BURST : RD_CMD;
          end
        end
        RD_CMD: begin
          if (mem_ready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (mem_rvalid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= DONE;
          end
        end
        WR_BURST: begin
          if (mem_ready) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= DONE;
          end
        end
        // Requests are deliberately not sampled here, so a request still
        // held high during the resp cycle is not taken a second time.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read line assembly; keeps its value until the next read overwrites it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata <= '0;
    end else if (state == RD_DATA && mem_rvalid) begin
      for (int i = 0; i < BEATS; i++) begin
        if (cnt == CW'(i)) resp_rdata[i*BEAT_BITS +: BEAT_BITS] <= mem_rdata;
      end
    end
  end

  // Memory-port command outputs decoded from the current state.
  always_comb begin
    mem_read  = (state == RD_CMD);
    mem_write = (state == WR_BURST);
    resp      = (state == DONE);
    mem_addr  = {addr_q[31:OFF], {OFF{1'b0}}};
    mem_wdata = '0;
    if (state == WR_BURST) begin
      for (int i = 0; i < BEATS; i++) begin
        if (cnt == CW'(i)) mem_wdata = wdata_q[i*BEAT_BITS +: BEAT_BITS];
      end
    end
    dbg_state = state;
  end

endmodule

// File: tb/tb_l2_line_responder.sv
// Bench for l2_line_responder: table-driven directed requests, hand-written
// corner sequences, then randomized traffic against a line-level memory model.
module tb_l2_line_responder;
  localparam int LB = 256;
  localparam int BB = 64;
  localparam int NB = LB / BB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req_read, req_write;
  logic [31:0]   req_addr;
  logic [LB-1:0] req_wdata;
  logic          resp;
  logic [LB-1:0] resp_rdata;
  logic [31:0]   mem_addr;
  logic          mem_read, mem_write;
  logic [BB-1:0] mem_wdata;
  logic          mem_ready;
  logic [BB-1:0] mem_rdata;
  logic          mem_rvalid;
  logic [2:0]    dbg_state;

  l2_line_responder #(.LINE_BITS(LB), .BEAT_BITS(BB)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp(resp), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- memory agent ----------------
  logic [BB-1:0] mem_store [int unsigned];
  int   fixed_wait = 0;   // -1: random 0..2 wait cycles per handshake
  int   rv_gap = 0;       // rvalid asserted with probability 1/(rv_gap+1)
  bit   stray = 1'b0;     // drive junk rvalid whenever no read is active
  logic [31:0] exp_line = '0;
  int   rd_cmd_cycles = 0, wr_accepts = 0, rd_accepts = 0;
  int   addr_errs = 0, overlap_errs = 0, resp_cnt = 0;
  int   wait_ctr = 0, cur_wait = 0, rbeat = 0, wbeat = 0;
  bit   have_wait = 1'b0, rd_active = 1'b0;
  logic [31:0] rd_line = '0;

  function automatic logic [BB-1:0] init_beat(input logic [31:0] a);
    return {~a, a};
  endfunction

  function automatic logic [BB-1:0] get_beat(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return init_beat(a);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      rd_active = 1'b0; wait_ctr = 0; have_wait = 1'b0; rbeat = 0; wbeat = 0;
    end else begin
      if (resp) resp_cnt++;
      if (mem_read && mem_write) overlap_errs++;
      if ((mem_read || mem_write) && mem_addr !== exp_line) addr_errs++;
      if (mem_read) rd_cmd_cycles++;
      if (!mem_write) wbeat = 0;
      // read beats for the cycle after a command was taken onwards
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
      if (rd_active) begin
        if ($urandom_range(0, rv_gap) == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = get_beat(rd_line + 32'(rbeat * 8));
          rbeat++;
          if (rbeat == NB) rd_active = 1'b0;
        end
      end else if (stray) begin
        mem_rvalid = 1'b1;
      end
      // ready with wait states
      mem_ready = 1'b0;
      if (mem_read || mem_write) begin
        if (!have_wait) begin
          cur_wait  = (fixed_wait < 0) ? int'($urandom_range(0, 2)) : fixed_wait;
          have_wait = 1'b1;
        end
        if (wait_ctr >= cur_wait) begin
          mem_ready = 1'b1; wait_ctr = 0; have_wait = 1'b0;
          if (mem_read) begin
            rd_active = 1'b1; rbeat = 0; rd_line = mem_addr; rd_accepts++;
          end else begin
            mem_store[mem_addr + 32'(wbeat * 8)] = mem_wdata;
            wbeat++; wr_accepts++;
          end
        end else begin
          wait_ctr++;
        end
      end else begin
        wait_ctr = 0; have_wait = 1'b0;
      end
    end
  end

  // ---------------- reference model (whole lines) ----------------
  logic [LB-1:0] ref_line [int unsigned];
  logic [LB-1:0] last_rd_exp = '0;

  function automatic logic [LB-1:0] ref_read(input logic [31:0] line);
    logic [LB-1:0] l;
    if (ref_line.exists(line)) return ref_line[line];
    for (int i = 0; i < NB; i++) l[i*BB +: BB] = init_beat(line + 32'(i * 8));
    return l;
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int i = 0; i < LB / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // ---------------- driver ----------------
  // Called just after a negedge. Holds the request until resp (plus 'hold'
  // extra cycles), scrambling addr/wdata mid-burst when hold==0.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [LB-1:0] wd, input int hold, output int lat);
    logic [31:0] line;
    line = {addr[31:5], 5'b0};
    exp_line  = line;
    req_read  = rd; req_write = wr; req_addr = addr; req_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (hold == 0 && lat >= 1 && !resp) begin
        req_addr = $urandom; req_wdata = rand_line();
      end
    end while (!resp && lat < 400);
    check("resp_timeout", {255'b0, resp}, {255'b0, 1'b1});
    if (resp) begin
      if (wr) begin
        ref_line[line] = wd;
        check("rdata_kept_on_write", resp_rdata, last_rd_exp);
      end else begin
        last_rd_exp = ref_read(line);
        check("rdata", resp_rdata, last_rd_exp);
      end
    end
    repeat (hold) @(negedge clk);
    req_read = 1'b0; req_write = 1'b0;
  endtask

  typedef struct {
    bit rd; bit wr; logic [31:0] addr; int wt;
    int exp_lat; int exp_cmd; int exp_wbeats;
  } vec_t;

  vec_t vecs [7];
  logic [LB-1:0] ex_line;
  int lat, b_resp, b_cmd, b_wr, b_rd, n;

  initial begin
    req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    // memory image of the documented read example
    for (int i = 0; i < NB; i++) mem_store[32'h1220 + 32'(i * 8)] = 64'hA0 + 64'(i);
    ex_line = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    ref_line[32'h1220] = ex_line;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 0,  6, 1, 0};
    vecs[1] = '{1'b0, 1'b1, 32'h8000_0040, 2, 13, 0, 4};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_2000, 0,  5, 0, 4};
    vecs[3] = '{1'b1, 1'b0, 32'h8000_0040, 1,  7, 2, 0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_201F, 0,  6, 1, 0};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFE0, 1,  9, 0, 4};
    vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 2,  8, 3, 0};

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_resp", {255'b0, resp}, '0);
    check("rst_mem_cmds", {254'b0, mem_read, mem_write}, '0);
    check("rst_mem_addr", {224'b0, mem_addr}, '0);
    check("rst_mem_wdata", {192'b0, mem_wdata}, '0);
    check("rst_resp_rdata", resp_rdata, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // directed table
    foreach (vecs[k]) begin
      fixed_wait = vecs[k].wt; rv_gap = 0;
      b_resp = resp_cnt; b_cmd = rd_cmd_cycles; b_wr = wr_accepts;
      do_req(vecs[k].rd, vecs[k].wr, vecs[k].addr, rand_line(), 0, lat);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_latency", k), LB'(lat), LB'(vecs[k].exp_lat));
      check($sformatf("v%0d_rd_cmd_cycles", k), LB'(rd_cmd_cycles - b_cmd), LB'(vecs[k].exp_cmd));
      check($sformatf("v%0d_wr_beats", k), LB'(wr_accepts - b_wr), LB'(vecs[k].exp_wbeats));
      check($sformatf("v%0d_resp_count", k), LB'(resp_cnt - b_resp), LB'(1));
    end

    // documented read example, data compared with literal beats
    fixed_wait = 0;
    do_req(1'b1, 1'b0, 32'h0000_1234, '0, 0, lat);
    check("example_rdata", resp_rdata, ex_line);
    @(negedge clk);

    // reset in the middle of a write burst (beat 2 presented)
    b_resp = resp_cnt; b_wr = wr_accepts;
    exp_line = 32'h4000_0000;
    req_write = 1'b1; req_addr = 32'h4000_0000; req_wdata = rand_line();
    n = 0;
    do begin @(negedge clk); #1; n++; end while (wr_accepts != b_wr + 2 && n < 50);
    check("midburst_reach_beat2", LB'(wr_accepts - b_wr), LB'(2));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_resp", {255'b0, resp}, '0);
    check("midrst_mem_cmds", {254'b0, mem_read, mem_write}, '0);
    check("midrst_mem_addr", {224'b0, mem_addr}, '0);
    check("midrst_mem_wdata", {192'b0, mem_wdata}, '0);
    check("midrst_resp_rdata", resp_rdata, '0);
    req_write = 1'b0;
    last_rd_exp = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_resp", LB'(resp_cnt - b_resp), '0);
    do_req(1'b1, 1'b0, 32'h8000_0040, '0, 0, lat);
    check("post_rst_latency", LB'(lat), LB'(6));
    @(negedge clk);

    // request held for 3 cycles after resp: re-taken only from IDLE
    b_resp = resp_cnt; b_rd = rd_accepts;
    exp_line = 32'h0000_2000;
    req_read = 1'b1; req_addr = 32'h0000_2000;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp && n < 50);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 3) req_read = 1'b0;
    end while (!resp && n < 50);
    check("held_second_resp_gap", LB'(n), LB'(7));
    check("held_second_rdata", resp_rdata, ref_read(32'h0000_2000));
    last_rd_exp = ref_read(32'h0000_2000);
    repeat (10) @(negedge clk);
    check("held_resp_count", LB'(resp_cnt - b_resp), LB'(2));
    check("held_rd_accepts", LB'(rd_accepts - b_rd), LB'(2));

    // stray rvalid during IDLE and WR_BURST
    stray = 1'b1;
    repeat (3) @(negedge clk);
    do_req(1'b0, 1'b1, 32'h0000_0140, rand_line(), 0, lat);
    repeat (3) @(negedge clk);
    check("stray_rdata_untouched", resp_rdata, last_rd_exp);
    stray = 1'b0;
    @(negedge clk);
    do_req(1'b1, 1'b0, 32'h0000_0140, '0, 0, lat);
    @(negedge clk);

    // randomized traffic
    fixed_wait = -1; rv_gap = 2;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      bit r, w;
      case ($urandom_range(0, 4))
        0: a = 32'h0000_0100;
        1: a = 32'h0000_0120;
        2: a = 32'h0000_0140;
        3: a = 32'h8000_0040;
        default: a = 32'h0000_1220;
      endcase
      a[4:0] = 5'($urandom);
      r = 1'($urandom); w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      b_resp = resp_cnt;
      do_req(r, w, a, rand_line(), 0, lat);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      check($sformatf("rand%0d_resp_count", t), LB'(resp_cnt - b_resp), LB'(1));
    end

    check("mem_addr_errors", LB'(addr_errs), '0);
    check("read_write_overlap", LB'(overlap_errs), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
